// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result bundle between decode control and the shift sequencer
interface shift_sequencer_if #(
  parameter int nBit  = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic             sh_cond;
  logic [nBit-1:0]  operand;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic             busy;
  logic             done;
  logic [nBit-1:0]  result;
  modport master (output start, sh_cond, operand, amount, input ready, busy, done, result);
  modport slave  (input start, sh_cond, operand, amount, output ready, busy, done, result);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRA controller stepping a one-bit shift stage per clock
module shift_sequencer #(
  parameter int nBit  = 16,
  parameter int AMT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_nx;
  logic [nBit-1:0]  work, work_nx;
  logic [AMT_W-1:0] cnt, cnt_nx;
  logic             cond, cond_nx;
  logic             accept;
  // state, working register, step count and latched direction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      cond  <= 1'b0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
      cond  <= cond_nx;
    end
  end
  // accept a new request when not shifting, otherwise step the one-bit stage and count down
  always_comb begin
    accept   = bus.start && state != SHIFT;
    work_nx  = work;
    cnt_nx   = cnt;
    cond_nx  = cond;
    state_nx = IDLE;
    if (accept) begin
      work_nx  = bus.operand;
      cnt_nx   = bus.amount;
      cond_nx  = bus.sh_cond;
      state_nx = bus.amount != '0 ? SHIFT : DONE;
    end else if (state == SHIFT) begin
      work_nx  = cond ? {work[nBit-1], work[nBit-1:1]} : {work[nBit-2:0], 1'b0};
      cnt_nx   = cnt - 1'b1;
      state_nx = cnt == AMT_W'(1) ? DONE : SHIFT;
    end
  end
  assign bus.ready  = state != SHIFT;
  assign bus.busy   = state == SHIFT;
  assign bus.done   = state == DONE;
  assign bus.result = work;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table vectors, corner sequences and random ops against a shift model
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  shift_sequencer_if #(.nBit(16), .AMT_W(4)) bus();
  shift_sequencer #(.nBit(16), .AMT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] op;
    logic        cond;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [8];
  function automatic logic [15:0] model(input logic [15:0] op, input logic cond, input logic [3:0] amt);
    logic signed [15:0] s;
    s = op;
    return cond ? 16'(s >>> amt) : 16'(op << amt);
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic issue(input logic [15:0] op, input logic cond, input logic [3:0] amt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.operand = op;
    bus.sh_cond = cond;
    bus.amount = amt;
  endtask
  // called before the acceptance edge; counts negedges until done and busy cycles seen
  task automatic wait_done(input string nm, input int n, input logic [15:0] exp, input bit drop, input int glitch, input bit scramble);
    int c = 0;
    int b = 0;
    @(negedge clk);
    if (drop) bus.start = 1'b0;
    if (scramble) begin
      bus.operand = 16'($urandom);
      bus.amount = 4'($urandom);
      bus.sh_cond = 1'($urandom);
    end
    while (!bus.done && c < 64) begin
      if (bus.busy) b++;
      c++;
      if (c == glitch) begin
        bus.start = 1'b1;
        bus.operand = 16'hAAAA;
      end else if (c == glitch + 1) bus.start = 1'b0;
      @(negedge clk);
    end
    chk({nm, " latency"}, c, n);
    chk({nm, " result"}, bus.result, exp);
    chk({nm, " busy_cycles"}, b, n);
    chk({nm, " ready_at_done"}, bus.ready, 1);
  endtask
  initial begin
    int dn;
    bus.start = 1'b0;
    bus.operand = '0;
    bus.sh_cond = 1'b0;
    bus.amount = '0;
    vecs[0] = '{16'h0003, 1'b0, 4'd4, 16'h0030};
    vecs[1] = '{16'h8000, 1'b1, 4'd3, 16'hF000};
    vecs[2] = '{16'h4000, 1'b1, 4'd3, 16'h0800};
    vecs[3] = '{16'h1234, 1'b0, 4'd0, 16'h1234};
    vecs[4] = '{16'hFFFF, 1'b0, 4'd15, 16'h8000};
    vecs[5] = '{16'h8001, 1'b1, 4'd15, 16'hFFFF};
    vecs[6] = '{16'h9234, 1'b1, 4'd0, 16'h9234};
    vecs[7] = '{16'h8001, 1'b0, 4'd1, 16'h0002};
    bus.start = 1'b1;
    bus.operand = 16'h5555;
    bus.amount = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset result", bus.result, 0);
    chk("reset ready", bus.ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].cond, vecs[i].amt);
      wait_done($sformatf("vec%0d", i), int'(vecs[i].amt), vecs[i].exp, 1'b1, -1, 1'b0);
    end
    @(negedge clk);
    chk("done one cycle", bus.done, 0);
    chk("idle after done", bus.ready, 1);
    issue(16'h0F0F, 1'b0, 4'd6);
    wait_done("ignored start", 6, 16'hC3C0, 1'b1, 2, 1'b0);
    @(negedge clk);
    chk("ignored start no extra op", bus.busy, 0);
    chk("ignored start idle done", bus.done, 0);
    issue(16'h0011, 1'b0, 4'd2);
    wait_done("b2b first", 2, 16'h0044, 1'b0, -1, 1'b0);
    bus.operand = 16'h8100;
    bus.sh_cond = 1'b1;
    bus.amount = 4'd4;
    wait_done("b2b second", 4, 16'hF810, 1'b1, -1, 1'b0);
    issue(16'h00FF, 1'b0, 4'd8);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset result", bus.result, 0);
    chk("midreset busy", bus.busy, 0);
    chk("midreset ready", bus.ready, 1);
    dn = 0;
    repeat (12) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("midreset no done", dn, 0);
    issue(16'h00FF, 1'b0, 4'd8);
    wait_done("after reset", 8, 16'hFF00, 1'b1, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] op;
      logic        cd;
      logic [3:0]  am;
      op = 16'($urandom);
      cd = 1'($urandom);
      am = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, cd, am);
      wait_done($sformatf("rand%0d", i), int'(am), model(op, cd, am), 1'b1, -1, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
